// File: rtl/tlcd_responder.sv
// tlcd_responder
//
// Device-side model of a 2x16 HD44780-style character LCD. It watches the
// TLCD_E/RS/RW/DATA bus driven by the text controller and decodes each bus
// transaction into DDRAM/CGRAM contents, an address counter and a busy flag.
// A host-side read port exposes the 32 visible characters.
//
// Ports
//   CLK            system clock, all logic on the rising edge
//   RESET          synchronous, active-high reset
//   TLCD_E         bus enable, asynchronous to CLK
//   TLCD_RS        0 = instruction/status, 1 = data
//   TLCD_RW        0 = write, 1 = read
//   TLCD_DATA_IN   bus data from the controller
//   TLCD_DATA_OUT  read data returned to the controller
//   TLCD_DATA_OE   high while the responder drives the bus
//   RD_ADDR        host read index: bit 4 = line, bits 3:0 = column
//   RD_CHAR        DDRAM character at RD_ADDR, one cycle latency
//   XFER_DONE      one-cycle pulse per accepted transaction
//   DISP_ON        D bit of the last display-control instruction
//   ERR_BUSY       sticky flag: a write arrived while busy
//
// Parameters
//   BUSY_CYCLES        busy time after an ordinary instruction or data write
//   CLEAR_BUSY_CYCLES  busy time after clear and return-home
//
// Configuration macro
//   TLCD_RESP_BUSY_CHECK_EN  when defined, writes arriving while busy are
//                            discarded and flagged on ERR_BUSY. When undefined
//                            every transaction executes and ERR_BUSY is 0.

module tlcd_responder #(
    parameter int BUSY_CYCLES       = 2000,
    parameter int CLEAR_BUSY_CYCLES = 82000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       TLCD_E,
    input  logic       TLCD_RS,
    input  logic       TLCD_RW,
    input  logic [7:0] TLCD_DATA_IN,
    output logic [7:0] TLCD_DATA_OUT,
    output logic       TLCD_DATA_OE,
    input  logic [4:0] RD_ADDR,
    output logic [7:0] RD_CHAR,
    output logic       XFER_DONE,
    output logic       DISP_ON,
    output logic       ERR_BUSY
);

    localparam int MAX_BUSY = (BUSY_CYCLES > CLEAR_BUSY_CYCLES) ? BUSY_CYCLES : CLEAR_BUSY_CYCLES;
    localparam int CNT_W    = $clog2(MAX_BUSY + 1);

    // The counter holds N-1 right after the event so it reaches zero exactly
    // N cycles after the transaction.
    localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_BUSY_CYCLES - 1);

    typedef enum logic [1:0] {
        BUS_WAIT_LOW,
        BUS_IDLE,
        BUS_ACTIVE
    } busState_e;

    logic       eMeta_q, eSync_q;
    logic       rsMeta_q, rsSync_q;
    logic       rwMeta_q, rwSync_q;
    logic [7:0] dataMeta_q, dataSync_q;

    logic       capRs_q, capRw_q;
    logic [7:0] capData_q;

    busState_e  busState_q, busState_d;
    logic       eventFire, readStart;

    logic [6:0]       ac_q, ac_d;
    logic             cgTarget_q, cgTarget_d;
    logic             incr_q, incr_d;
    logic             dispOn_q, dispOn_d;
    logic [CNT_W-1:0] busyCnt_q, busyCnt_d;
    logic             xferDone_q, xferDone_d;
    logic [7:0]       dataOut_q, dataOut_d;
    logic [7:0]       rdChar_q;

    logic [7:0] ddram_q [32];
    logic [4:0] cgram_q [64];

    logic       busy;
    logic       writeBlocked;
    logic       accept;
    logic       acMapped;
    logic [4:0] ddIdx;
    logic [7:0] ramRead;
    logic       ddWe, cgWe, clearAll;

    // Step the address counter. DDRAM walks the two 40-cell lines as one
    // 80-cell ring (0x27 joins 0x40, 0x67 joins 0x00); CGRAM is a 6-bit ring.
    function automatic logic [6:0] stepAc(input logic [6:0] ac, input logic up, input logic cg);
        logic [6:0] res;
        if (cg) begin
            res = {1'b0, (up ? ac[5:0] + 6'd1 : ac[5:0] - 6'd1)};
        end else if (up) begin
            if (ac == 7'h27)      res = 7'h40;
            else if (ac == 7'h67) res = 7'h00;
            else                  res = ac + 7'd1;
        end else begin
            if (ac == 7'h00)      res = 7'h67;
            else if (ac == 7'h40) res = 7'h27;
            else                  res = ac - 7'd1;
        end
        return res;
    endfunction

    // Two-flop synchronizers for the whole bus. Enable resets high so that a
    // strobe already in progress when reset releases is never mistaken for a
    // fresh rising edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            eMeta_q    <= 1'b1;
            eSync_q    <= 1'b1;
            rsMeta_q   <= 1'b0;
            rsSync_q   <= 1'b0;
            rwMeta_q   <= 1'b0;
            rwSync_q   <= 1'b0;
            dataMeta_q <= '0;
            dataSync_q <= '0;
        end else begin
            eMeta_q    <= TLCD_E;
            eSync_q    <= eMeta_q;
            rsMeta_q   <= TLCD_RS;
            rsSync_q   <= rsMeta_q;
            rwMeta_q   <= TLCD_RW;
            rwSync_q   <= rwMeta_q;
            dataMeta_q <= TLCD_DATA_IN;
            dataSync_q <= dataMeta_q;
        end
    end

    // Bus phase tracker. After reset it waits for enable to be seen low, so
    // only a complete low-high-low strobe produces a transaction event.
    always_ff @(posedge CLK) begin
        if (RESET) busState_q <= BUS_WAIT_LOW;
        else       busState_q <= busState_d;
    end

    always_comb begin
        busState_d = busState_q;
        eventFire  = 1'b0;
        readStart  = 1'b0;
        case (busState_q)
            BUS_WAIT_LOW: begin
                if (!eSync_q) busState_d = BUS_IDLE;
            end
            BUS_IDLE: begin
                if (eSync_q) begin
                    busState_d = BUS_ACTIVE;
                    readStart  = rwSync_q;
                end
            end
            BUS_ACTIVE: begin
                if (!eSync_q) begin
                    busState_d = BUS_IDLE;
                    eventFire  = 1'b1;
                end
            end
            default: busState_d = BUS_WAIT_LOW;
        endcase
    end

    assign busy     = (busyCnt_q != '0);
    assign acMapped = (ac_q[5:4] == 2'b00);
    assign ddIdx    = {ac_q[6], ac_q[3:0]};

`ifdef TLCD_RESP_BUSY_CHECK_EN
    assign writeBlocked = eventFire && !capRw_q && busy;
`else
    assign writeBlocked = 1'b0;
`endif

    assign accept = eventFire && !writeBlocked;

    // Value a data read would return at the current address.
    always_comb begin
        if (cgTarget_q)    ramRead = {3'b000, cgram_q[ac_q[5:0]]};
        else if (acMapped) ramRead = ddram_q[ddIdx];
        else               ramRead = 8'h20;
    end

    // Transaction decode. Instructions are classified by their highest set
    // bit; data writes and data reads both advance the address counter.
    always_comb begin
        ac_d       = ac_q;
        cgTarget_d = cgTarget_q;
        incr_d     = incr_q;
        dispOn_d   = dispOn_q;
        busyCnt_d  = busy ? busyCnt_q - CNT_W'(1) : '0;
        xferDone_d = 1'b0;
        dataOut_d  = dataOut_q;
        ddWe       = 1'b0;
        cgWe       = 1'b0;
        clearAll   = 1'b0;

        if (readStart) begin
            dataOut_d = rsSync_q ? ramRead : {busy, ac_q};
        end

        if (accept) begin
            xferDone_d = 1'b1;
            if (!capRw_q) begin
                busyCnt_d = BUSY_LOAD;
                if (!capRs_q) begin
                    casez (capData_q)
                        8'b1???????: begin
                            ac_d       = capData_q[6:0];
                            cgTarget_d = 1'b0;
                        end
                        8'b01??????: begin
                            ac_d       = {1'b0, capData_q[5:0]};
                            cgTarget_d = 1'b1;
                        end
                        8'b0001????: begin
                            if (!capData_q[3]) ac_d = stepAc(ac_q, capData_q[2], cgTarget_q);
                        end
                        8'b00001???: dispOn_d = capData_q[2];
                        8'b000001??: incr_d   = capData_q[1];
                        8'b0000001?: begin
                            ac_d       = '0;
                            cgTarget_d = 1'b0;
                            busyCnt_d  = CLEAR_LOAD;
                        end
                        8'b00000001: begin
                            clearAll   = 1'b1;
                            ac_d       = '0;
                            cgTarget_d = 1'b0;
                            incr_d     = 1'b1;
                            busyCnt_d  = CLEAR_LOAD;
                        end
                        default: begin
                            // function set and 0x00 have no visible effect
                        end
                    endcase
                end else begin
                    if (cgTarget_q)    cgWe = 1'b1;
                    else if (acMapped) ddWe = 1'b1;
                    ac_d = stepAc(ac_q, incr_q, cgTarget_q);
                end
            end else if (capRs_q) begin
                ac_d = stepAc(ac_q, incr_q, cgTarget_q);
            end
        end
    end

    // Control registers plus the per-cycle capture of the synchronized bus
    // while enable is high; the falling edge decodes the last capture.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            capRs_q    <= 1'b0;
            capRw_q    <= 1'b0;
            capData_q  <= '0;
            ac_q       <= '0;
            cgTarget_q <= 1'b0;
            incr_q     <= 1'b1;
            dispOn_q   <= 1'b0;
            busyCnt_q  <= '0;
            xferDone_q <= 1'b0;
            dataOut_q  <= 8'h00;
        end else begin
            if (eSync_q) begin
                capRs_q   <= rsSync_q;
                capRw_q   <= rwSync_q;
                capData_q <= dataSync_q;
            end
            ac_q       <= ac_d;
            cgTarget_q <= cgTarget_d;
            incr_q     <= incr_d;
            dispOn_q   <= dispOn_d;
            busyCnt_q  <= busyCnt_d;
            xferDone_q <= xferDone_d;
            dataOut_q  <= dataOut_d;
        end
    end

    // Character and glyph storage. The host read port samples DDRAM before
    // this cycle's write lands, so a same-cycle write shows up one cycle later.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++) ddram_q[i] <= 8'h20;
            for (int i = 0; i < 64; i++) cgram_q[i] <= 5'h00;
            rdChar_q <= 8'h20;
        end else begin
            rdChar_q <= ddram_q[RD_ADDR];
            if (clearAll) begin
                for (int i = 0; i < 32; i++) ddram_q[i] <= 8'h20;
            end else if (ddWe) begin
                ddram_q[ddIdx] <= capData_q;
            end
            if (cgWe) cgram_q[ac_q[5:0]] <= capData_q[4:0];
        end
    end

`ifdef TLCD_RESP_BUSY_CHECK_EN
    logic errBusy_q;

    // Sticky until reset: any write that had to be thrown away.
    always_ff @(posedge CLK) begin
        if (RESET)             errBusy_q <= 1'b0;
        else if (writeBlocked) errBusy_q <= 1'b1;
    end

    assign ERR_BUSY = errBusy_q;
`else
    assign ERR_BUSY = 1'b0;
`endif

    assign TLCD_DATA_OE  = (busState_q != BUS_WAIT_LOW) && eSync_q && rwSync_q;
    assign TLCD_DATA_OUT = dataOut_q;
    assign RD_CHAR       = rdChar_q;
    assign XFER_DONE     = xferDone_q;
    assign DISP_ON       = dispOn_q;

endmodule

// File: tb/tb_tlcd_responder.sv
// tb_tlcd_responder
//
// Self-checking bench for tlcd_responder. Bus transactions are driven the way
// the text controller does it (E held high for several clocks), and results
// are compared against a reference model of the display: the DDRAM space is
// kept as an 80-cell ring (two 40-cell lines) with the cursor as a position
// in that ring.

module tb_tlcd_responder;

    localparam int TB_BUSY  = 40;
    localparam int TB_CLEAR = 300;

    logic       clock = 1'b0;
    logic       reset;
    logic       tlcdE;
    logic       tlcdRs;
    logic       tlcdRw;
    logic [7:0] tlcdDataIn;
    logic [7:0] tlcdDataOut;
    logic       tlcdDataOe;
    logic [4:0] rdAddr;
    logic [7:0] rdChar;
    logic       xferDone;
    logic       dispOn;
    logic       errBusy;

    int compareCount  = 0;
    int mismatchCount = 0;

    logic [7:0] modelMem [80];
    int         modelPos;
    bit         modelIncr;

    tlcd_responder #(
        .BUSY_CYCLES       (TB_BUSY),
        .CLEAR_BUSY_CYCLES (TB_CLEAR)
    ) dut (
        .CLK           (clock),
        .RESET         (reset),
        .TLCD_E        (tlcdE),
        .TLCD_RS       (tlcdRs),
        .TLCD_RW       (tlcdRw),
        .TLCD_DATA_IN  (tlcdDataIn),
        .TLCD_DATA_OUT (tlcdDataOut),
        .TLCD_DATA_OE  (tlcdDataOe),
        .RD_ADDR       (rdAddr),
        .RD_CHAR       (rdChar),
        .XFER_DONE     (xferDone),
        .DISP_ON       (dispOn),
        .ERR_BUSY      (errBusy)
    );

    always #5 clock = ~clock;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: cursor is a ring position, line = pos/40, column = pos%40.
    function automatic logic [6:0] acOf(input int pos);
        return 7'((pos / 40) * 64 + (pos % 40));
    endfunction

    task automatic modelStep(input bit up);
        modelPos = up ? (modelPos + 1) % 80 : (modelPos + 79) % 80;
    endtask

    task automatic modelClear();
        for (int i = 0; i < 80; i++) modelMem[i] = 8'h20;
        modelPos  = 0;
        modelIncr = 1'b1;
    endtask

    task automatic modelWriteData(input logic [7:0] d);
        if (modelPos % 40 < 16) modelMem[modelPos] = d;
        modelStep(modelIncr);
    endtask

    task automatic modelReadData(output logic [7:0] d);
        d = (modelPos % 40 < 16) ? modelMem[modelPos] : 8'h20;
        modelStep(modelIncr);
    endtask

    // One write strobe, then count XFER_DONE pulses and optionally wait out busy.
    task automatic applyStimulus(input logic rs, input logic [7:0] d, input int expPulses, input int idleWait);
        int pulses;
        @(negedge clock);
        tlcdRs     = rs;
        tlcdRw     = 1'b0;
        tlcdDataIn = d;
        tlcdE      = 1'b1;
        repeat (6) @(negedge clock);
        tlcdE  = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(negedge clock);
            if (xferDone) pulses++;
        end
        checkOutput(rs ? "data_xfer_done" : "instr_xfer_done", 32'(pulses), 32'(expPulses));
        repeat (idleWait) @(negedge clock);
    endtask

    task automatic writeInstr(input logic [7:0] d);
        applyStimulus(1'b0, d, 1, (d == 8'h01 || d == 8'h02 || d == 8'h03) ? TB_CLEAR : TB_BUSY);
    endtask

    task automatic writeData(input logic [7:0] d);
        applyStimulus(1'b1, d, 1, TB_BUSY);
    endtask

    task automatic readBus(input logic rs, output logic [7:0] v);
        int pulses;
        @(negedge clock);
        tlcdRs     = rs;
        tlcdRw     = 1'b1;
        tlcdDataIn = 8'($urandom);
        tlcdE      = 1'b1;
        repeat (6) @(negedge clock);
        checkOutput("read_oe_high", 32'(tlcdDataOe), 32'h1);
        v      = tlcdDataOut;
        tlcdE  = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(negedge clock);
            if (xferDone) pulses++;
        end
        checkOutput("read_xfer_done", 32'(pulses), 32'h1);
        checkOutput("read_oe_low", 32'(tlcdDataOe), 32'h0);
        tlcdRw = 1'b0;
    endtask

    task automatic checkStatus(input string tag, input logic [7:0] expected);
        logic [7:0] v;
        readBus(1'b0, v);
        checkOutput(tag, 32'(v), 32'(expected));
    endtask

    task automatic checkScreen(input string tag);
        for (int i = 0; i < 32; i++) begin
            rdAddr = 5'(i);
            @(negedge clock);
            checkOutput(tag, 32'(rdChar), 32'(modelMem[(i / 16) * 40 + (i % 16)]));
        end
    endtask

    // Hard stop in case the run stalls.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] v;
        logic [7:0] e;
        int         pulses;

        reset      = 1'b1;
        tlcdE      = 1'b0;
        tlcdRs     = 1'b0;
        tlcdRw     = 1'b0;
        tlcdDataIn = 8'h00;
        rdAddr     = 5'd0;
        modelClear();

        repeat (3) @(negedge clock);
        checkOutput("reset_oe", 32'(tlcdDataOe), 32'h0);
        checkOutput("reset_data_out", 32'(tlcdDataOut), 32'h00);
        checkOutput("reset_rd_char", 32'(rdChar), 32'h20);
        checkOutput("reset_xfer_done", 32'(xferDone), 32'h0);
        checkOutput("reset_disp_on", 32'(dispOn), 32'h0);
        checkOutput("reset_err_busy", 32'(errBusy), 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        checkStatus("reset_status", 8'h00);

        $display("[TB] writing Hi at line 0");
        writeInstr(8'h80);
        modelPos = 0;
        writeData(8'h48); modelWriteData(8'h48);
        writeData(8'h69); modelWriteData(8'h69);
        rdAddr = 5'd0; @(negedge clock);
        checkOutput("hi_char0", 32'(rdChar), 32'h48);
        rdAddr = 5'd1; @(negedge clock);
        checkOutput("hi_char1", 32'(rdChar), 32'h69);
        checkStatus("hi_status", 8'h02);

        $display("[TB] wrap from 0x27 to 0x40");
        writeInstr(8'hA7);
        modelPos = 39;
        writeData(8'h41); modelWriteData(8'h41);
        writeData(8'h42); modelWriteData(8'h42);
        rdAddr = 5'd16; @(negedge clock);
        checkOutput("wrap_char16", 32'(rdChar), 32'h42);
        checkStatus("wrap_status", 8'h41);
        checkScreen("wrap_screen");

        $display("[TB] CGRAM rows");
        writeInstr(8'h40);
        for (int i = 0; i < 8; i++) writeData(8'h1F);
        writeData(8'hEA);
        writeInstr(8'h80);
        writeInstr(8'h40);
        for (int i = 0; i < 8; i++) begin
            readBus(1'b1, v);
            checkOutput("cgram_row", 32'(v), 32'h1F);
        end
        readBus(1'b1, v);
        checkOutput("cgram_upper_bits", 32'(v), 32'h0A);
        checkStatus("cgram_ac", 8'h09);
        writeInstr(8'h7F);
        writeData(8'h15);
        checkStatus("cgram_ac_wrap", 8'h00);
        readBus(1'b1, v);
        checkOutput("cgram_wrap_read", 32'(v), 32'h1F);
        writeInstr(8'h7F);
        readBus(1'b1, v);
        checkOutput("cgram_last_row", 32'(v), 32'h15);
        writeInstr(8'h80);
        modelPos = 0;

        $display("[TB] display control");
        writeInstr(8'h0F);
        checkOutput("disp_on_set", 32'(dispOn), 32'h1);
        writeInstr(8'h08);
        checkOutput("disp_on_clear", 32'(dispOn), 32'h0);
        writeInstr(8'h0C);
        checkOutput("disp_on_again", 32'(dispOn), 32'h1);

        $display("[TB] fill screen then clear");
        writeInstr(8'h80);
        modelPos = 0;
        for (int i = 0; i < 16; i++) begin
            writeData(8'(8'h61 + i)); modelWriteData(8'(8'h61 + i));
        end
        writeInstr(8'hC0);
        modelPos = 40;
        for (int i = 0; i < 16; i++) begin
            writeData(8'(8'h41 + i)); modelWriteData(8'(8'h41 + i));
        end
        checkScreen("fill_screen");
        applyStimulus(1'b0, 8'h01, 1, 0);
        modelClear();
        checkStatus("clear_busy", 8'h80);
        repeat (TB_CLEAR) @(negedge clock);
        checkStatus("clear_idle", 8'h00);
        checkScreen("clear_screen");

        $display("[TB] write while busy");
        writeInstr(8'h80);
        modelPos = 0;
        applyStimulus(1'b1, 8'h58, 1, 0);
        modelWriteData(8'h58);
`ifdef TLCD_RESP_BUSY_CHECK_EN
        applyStimulus(1'b1, 8'h59, 0, TB_BUSY);
        checkOutput("busy_err_flag", 32'(errBusy), 32'h1);
`else
        applyStimulus(1'b1, 8'h59, 1, TB_BUSY);
        modelWriteData(8'h59);
        checkOutput("busy_err_flag", 32'(errBusy), 32'h0);
`endif
        checkScreen("busy_screen");
        checkStatus("busy_status", {1'b0, acOf(modelPos)});

        $display("[TB] randomized transactions");
        for (int n = 0; n < 80; n++) begin
            int r;
            int line;
            int col;
            bit b;
            r = $urandom_range(0, 99);
            if (r < 40) begin
                e = 8'($urandom_range(8'h21, 8'h7E));
                writeData(e);
                modelWriteData(e);
            end else if (r < 55) begin
                line = $urandom_range(0, 1);
                col  = $urandom_range(0, 19);
                writeInstr(8'(8'h80 + line * 64 + col));
                modelPos = line * 40 + col;
            end else if (r < 65) begin
                b = 1'($urandom_range(0, 1));
                writeInstr(8'(8'h04 + (b ? 2 : 0) + $urandom_range(0, 1)));
                modelIncr = b;
            end else if (r < 75) begin
                b = 1'($urandom_range(0, 1));
                writeInstr(8'(8'h10 + (b ? 4 : 0) + $urandom_range(0, 3)));
                modelStep(b);
            end else if (r < 85) begin
                readBus(1'b1, v);
                modelReadData(e);
                checkOutput("rand_data_read", 32'(v), 32'(e));
            end else if (r < 95) begin
                checkStatus("rand_status", {1'b0, acOf(modelPos)});
            end else if (r < 98) begin
                writeInstr(8'(8'h02 + $urandom_range(0, 1)));
                modelPos = 0;
            end else begin
                writeInstr(8'h01);
                modelClear();
            end
        end
        checkScreen("rand_screen");

        $display("[TB] reset during a data write");
        @(negedge clock);
        tlcdRs     = 1'b1;
        tlcdRw     = 1'b0;
        tlcdDataIn = 8'h51;
        tlcdE      = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        checkOutput("reset_mid_oe", 32'(tlcdDataOe), 32'h0);
        tlcdE  = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clock);
            if (xferDone) pulses++;
        end
        checkOutput("reset_mid_xfer_done", 32'(pulses), 32'h0);
        modelClear();
        checkScreen("reset_mid_screen");
        checkStatus("reset_mid_status", 8'h00);
        checkOutput("reset_mid_disp_on", 32'(dispOn), 32'h0);
        checkOutput("reset_mid_err_busy", 32'(errBusy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
